// File: rtl/conv_window_layer00_pkg.sv
// Shared sizes, types and the window layout helper for the layer-00 window stage.
package conv_window_layer00_pkg;

    localparam int LANES = 16;           // channel lanes per row vector
    localparam int DW    = 8;            // bits per lane element
    localparam int K     = 3;            // kernel height/width, fixed at 3
    localparam int COLW  = 9;            // width of the column index counter

    localparam int VEC_W = LANES * DW;   // one row vector (128)
    localparam int COL_W = K * VEC_W;    // one column of K row vectors (384)
    localparam int WIN_W = K * K * VEC_W; // full KxK window (1152)

    typedef logic [VEC_W-1:0] vec_t;
    typedef logic [COL_W-1:0] col_t;
    typedef logic [WIN_W-1:0] win_t;
    typedef logic [COLW-1:0]  idx_t;
    typedef logic [1:0]       fill_t;

    localparam fill_t FILL_WIN  = 2'd2;  // columns held before a new one completes a window
    localparam fill_t FILL_FULL = 2'd3;  // fill saturates here
    localparam idx_t  IDX_MAX   = '1;    // next-index saturates here

    // Bit offset of window element (r,c); r=0 top row, c=0 oldest column.
    function automatic int win_ofs(input int r, input int c);
        return (r * K + c) * VEC_W;
    endfunction

endpackage

// File: rtl/conv_window_layer00_if.sv
// Column input and window output bundle between the parser, this stage and the MAC array.
interface conv_window_layer00_if;
    import conv_window_layer00_pkg::*;

    logic iStart;
    logic iMac_vld;
    logic iColEnd;
    vec_t iDin0;
    vec_t iDin1;
    vec_t iDin2;
    win_t oWin;
    logic oWin_vld;
    logic oRowEnd;
    idx_t oColIdx;

    // Producer side: drives columns, observes windows.
    modport master (
        output iStart, iMac_vld, iColEnd, iDin0, iDin1, iDin2,
        input  oWin, oWin_vld, oRowEnd, oColIdx
    );

    // Window stage side.
    modport slave (
        input  iStart, iMac_vld, iColEnd, iDin0, iDin1, iDin2,
        output oWin, oWin_vld, oRowEnd, oColIdx
    );

endinterface

// File: rtl/conv_window_col_reg.sv
// One stored column (K row vectors) of the sliding window; loads on shift.
module conv_window_col_reg
    import conv_window_layer00_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic load_en_i,
    input  col_t col_i,
    output col_t col_o
);

    col_t col_d;
    col_t col_q;

    // Select the incoming column on a shift, otherwise hold.
    always_comb begin
        col_d = load_en_i ? col_i : col_q;
    end

    // Column storage register; cleared by reset so no stale data survives a restart.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values of its neighbours.
        if (!rstn) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign col_o = col_q;

endmodule

// File: rtl/conv_window_layer00.sv
// Sliding 3x3 window assembler: shifts parser columns through a 3-deep chain and
// emits one registered window per column once three columns of the current row are held.
module conv_window_layer00
    import conv_window_layer00_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    conv_window_layer00_if.slave  bus
);

    col_t din_col;
    col_t col0;
    col_t col1;
    col_t col2;
    col_t shifted [K];
    win_t win_set;

    logic  emit;

    fill_t fill_d,    fill_q;
    idx_t  idx_d,     idx_q;
    win_t  win_d,     win_q;
    logic  win_vld_d, win_vld_q;
    logic  row_end_d, row_end_q;
    idx_t  col_idx_d, col_idx_q;

    // Incoming column, row r at bits [r*VEC_W +: VEC_W].
    assign din_col = {bus.iDin2, bus.iDin1, bus.iDin0};

    // Column chain: newest column enters col2 and ages towards col0.
    conv_window_col_reg u_col2 (
        .clk       (clk),
        .rstn      (rstn),
        .load_en_i (bus.iMac_vld),
        .col_i     (din_col),
        .col_o     (col2)
    );

    conv_window_col_reg u_col1 (
        .clk       (clk),
        .rstn      (rstn),
        .load_en_i (bus.iMac_vld),
        .col_i     (col2),
        .col_o     (col1)
    );

    conv_window_col_reg u_col0 (
        .clk       (clk),
        .rstn      (rstn),
        .load_en_i (bus.iMac_vld),
        .col_i     (col1),
        .col_o     (col0)
    );

    // The window is taken from the column set as it will be after this shift,
    // so the emitted window appears exactly one cycle after its last column.
    assign shifted[0] = col1;
    assign shifted[1] = col2;
    assign shifted[2] = din_col;

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign win_set[win_ofs(r, c) +: VEC_W] = shifted[c][r*VEC_W +: VEC_W];
        end
    end

    // A frame start makes the incoming column the first one, so it never completes a window.
    assign emit = bus.iMac_vld && !bus.iStart && (fill_q >= FILL_WIN);

    // Fill / index / row-end control and window capture.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        fill_d    = fill_q;
        idx_d     = idx_q;
        win_d     = win_q;
        col_idx_d = col_idx_q;
        win_vld_d = 1'b0;
        row_end_d = 1'b0;

        if (bus.iMac_vld) begin
            if (bus.iStart) begin
                fill_d = 2'd1;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 2'd1;
            end
        end else if (bus.iStart) begin
            fill_d = '0;
        end

        if (bus.iStart) begin
            idx_d = '0;
        end

        if (emit) begin
            win_vld_d = 1'b1;
            win_d     = win_set;
            col_idx_d = idx_q;
            if (idx_q != IDX_MAX) begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Row end closes the row after any window this column produced.
        if (bus.iColEnd) begin
            row_end_d = 1'b1;
            fill_d    = '0;
            idx_d     = '0;
        end
    end

    // Control and output registers; window data holds between pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fill_q    <= '0;
            idx_q     <= '0;
            win_q     <= '0;
            win_vld_q <= 1'b0;
            row_end_q <= 1'b0;
            col_idx_q <= '0;
        end else begin
            fill_q    <= fill_d;
            idx_q     <= idx_d;
            win_q     <= win_d;
            win_vld_q <= win_vld_d;
            row_end_q <= row_end_d;
            col_idx_q <= col_idx_d;
        end
    end

    assign bus.oWin     = win_q;
    assign bus.oWin_vld = win_vld_q;
    assign bus.oRowEnd  = row_end_q;
    assign bus.oColIdx  = col_idx_q;

endmodule

// File: tb/tb_conv_window_layer00.sv
// Self-checking bench: directed scenarios plus random traffic against a column-history model.
module tb_conv_window_layer00;
    import conv_window_layer00_pkg::*;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    conv_window_layer00_if bus ();

    conv_window_layer00 dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: columns received since the last row/frame boundary.
    logic [383:0]  hist [$];
    int            n_win   = 0;
    logic [1151:0] exp_win = '0;
    logic          exp_vld = 1'b0;
    logic          exp_rend = 1'b0;
    int            exp_idx = 0;
    int            vld_seen = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [383:0] mk_col(input logic [127:0] d0, input logic [127:0] d1,
                                            input logic [127:0] d2);
        return {d2, d1, d0};
    endfunction

    function automatic logic [383:0] rnd_col();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [127:0] fill_vec(input logic [7:0] b);
        logic [127:0] v;
        for (int l = 0; l < 16; l++) v[l*8 +: 8] = b;
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model, then compare away from the edge.
    task automatic step(input bit rst_a, input bit st, input bit vld, input bit ce,
                        input logic [383:0] col);
        int n;
        rstn         = !rst_a;
        bus.iStart   = st;
        bus.iMac_vld = vld;
        bus.iColEnd  = ce;
        bus.iDin0    = col[0 +: 128];
        bus.iDin1    = col[128 +: 128];
        bus.iDin2    = col[256 +: 128];
        @(posedge clk);
        exp_vld  = 1'b0;
        exp_rend = 1'b0;
        if (rst_a) begin
            hist.delete();
            n_win   = 0;
            exp_win = '0;
            exp_idx = 0;
        end else begin
            if (st) begin
                hist.delete();
                n_win = 0;
            end
            if (vld) begin
                hist.push_back(col);
                n = hist.size();
                if (n >= 3) begin
                    exp_vld = 1'b1;
                    for (int c = 0; c < 3; c++)
                        for (int r = 0; r < 3; r++)
                            exp_win[(r*3 + c)*128 +: 128] = hist[n-3+c][r*128 +: 128];
                    exp_idx = n_win;
                    if (n_win < 511) n_win++;
                end
                if (hist.size() > 3) void'(hist.pop_front());
            end
            if (ce) begin
                hist.delete();
                n_win    = 0;
                exp_rend = 1'b1;
            end
        end
        @(negedge clk);
        if (bus.oWin_vld === 1'b1) vld_seen++;
        check("win_vld", 128'(bus.oWin_vld), 128'(exp_vld));
        check("row_end", 128'(bus.oRowEnd), 128'(exp_rend));
        check("col_idx", 128'(bus.oColIdx), 128'(exp_idx));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("win r%0d c%0d", r, c), bus.oWin[(r*3 + c)*128 +: 128],
                      exp_win[(r*3 + c)*128 +: 128]);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, rnd_col());
    endtask

    logic [383:0] cols [6];
    logic [127:0] lane_exp;
    bit           st, vld, ce, ra;

    initial begin
        // Reset state.
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);

        // Reset mid-stream: two partial columns are discarded.
        step(0, 0, 1, 0, rnd_col());
        step(0, 0, 1, 0, rnd_col());
        step(1, 0, 0, 0, rnd_col());
        vld_seen = 0;
        step(0, 0, 1, 0, mk_col(fill_vec(8'hAA), fill_vec(8'hAA), fill_vec(8'hAA)));
        step(0, 0, 1, 0, mk_col(fill_vec(8'hBB), fill_vec(8'hBB), fill_vec(8'hBB)));
        step(0, 0, 1, 0, mk_col(fill_vec(8'hCC), fill_vec(8'hCC), fill_vec(8'hCC)));
        check("rst idx0", 128'(bus.oColIdx), 128'd0);
        check("rst colA", bus.oWin[win_ofs(1, 0) +: 128], fill_vec(8'hAA));
        check("rst colB", bus.oWin[win_ofs(1, 1) +: 128], fill_vec(8'hBB));
        check("rst colC", bus.oWin[win_ofs(1, 2) +: 128], fill_vec(8'hCC));
        check("rst one window", 128'(vld_seen), 128'd1);
        step(0, 0, 0, 1, rnd_col());

        // Row of six back-to-back columns.
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cols[i] = rnd_col();
            step(0, 0, 1, (i == 5), cols[i]);
        end
        check("row6 windows", 128'(vld_seen), 128'd4);
        check("row6 last idx", 128'(bus.oColIdx), 128'd3);
        check("row6 last rowend", 128'(bus.oRowEnd), 128'd1);
        check("row6 last c0", bus.oWin[win_ofs(2, 0) +: 128], cols[3][256 +: 128]);
        check("row6 last c2", bus.oWin[win_ofs(0, 2) +: 128], cols[5][0 +: 128]);
        vld_seen = 0;
        step(0, 0, 1, 0, rnd_col());
        step(0, 0, 1, 0, rnd_col());
        check("new row no window", 128'(vld_seen), 128'd0);
        step(0, 0, 0, 1, rnd_col());

        // Gapped input: one column every third cycle.
        vld_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, rnd_col());
            idle();
            idle();
        end
        check("gapped windows", 128'(vld_seen), 128'd3);

        // Short row: two columns then a bare row end.
        step(0, 0, 0, 1, rnd_col());
        vld_seen = 0;
        step(0, 0, 1, 0, rnd_col());
        step(0, 0, 1, 0, rnd_col());
        step(0, 0, 0, 1, rnd_col());
        check("short row end", 128'(bus.oRowEnd), 128'd1);
        idle();
        check("short row end pulse", 128'(bus.oRowEnd), 128'd0);
        check("short no window", 128'(vld_seen), 128'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, rnd_col());
        check("short next idx0", 128'(bus.oColIdx), 128'd0);
        step(0, 0, 0, 1, rnd_col());

        // Frame start coincident with a column after four columns.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, rnd_col());
        vld_seen = 0;
        step(0, 1, 1, 0, rnd_col());
        step(0, 0, 1, 0, rnd_col());
        check("start no window", 128'(vld_seen), 128'd0);
        step(0, 0, 1, 0, rnd_col());
        check("start window", 128'(bus.oWin_vld), 128'd1);
        check("start idx0", 128'(bus.oColIdx), 128'd0);
        step(0, 0, 0, 1, rnd_col());

        // Lane ordering.
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++)
                for (int l = 0; l < 16; l++)
                    cols[c][r*128 + l*8 +: 8] = 8'(r*16 + l + 64*c);
            step(0, 0, 1, 0, cols[c]);
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                for (int l = 0; l < 16; l++) lane_exp[l*8 +: 8] = 8'(r*16 + l + 64*c);
                check($sformatf("lanes r%0d c%0d", r, c), bus.oWin[(r*3 + c)*128 +: 128], lane_exp);
            end
        step(0, 0, 0, 1, rnd_col());

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            ra  = ($urandom_range(0, 63) == 0);
            st  = ($urandom_range(0, 31) == 0);
            vld = ($urandom_range(0, 3) != 0);
            ce  = ($urandom_range(0, 7) == 0);
            if (st && vld) ce = 1'b0;
            step(ra, st, vld, ce, rnd_col());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
